// File: rtl/sp_ram_fifo_pkg.sv
// Shared constants, grant type and read-latency helper for the single-port RAM FIFO controller.
package sp_ram_fifo_pkg;

  localparam int unsigned OBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_WR,
    GNT_RD
  } gnt_e;

  // RAM read latency in cycles: an output register adds one stage.
  function automatic int unsigned rd_lat(input string dout_reg);
    return (dout_reg == "true") ? 32'd2 : 32'd1;
  endfunction

endpackage

// File: rtl/sp_ram_fifo_obuf.sv
// Four-entry register FIFO that absorbs RAM read latency; simultaneous push and pop are both
// honoured, and the head is taken straight from a register so it holds while stalled.
module sp_ram_fifo_obuf
  import sp_ram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH_DATA-1:0] push_data,
  input  logic                  pop,
  output logic [2:0]            count,
  output logic                  head_valid,
  output logic [WIDTH_DATA-1:0] head_data
);

  logic [WIDTH_DATA-1:0] buf_q [OBUF_DEPTH];
  logic [1:0]            wr_q, rd_q;
  logic [2:0]            cnt_q;
  logic                  do_push, do_pop;

  assign do_pop  = pop && (cnt_q != 3'd0);
  assign do_push = push && ((cnt_q != 3'(OBUF_DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) buf_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        buf_q[wr_q] <= push_data;
        wr_q        <= wr_q + 2'd1;
      end
      if (do_pop) rd_q <= rd_q + 2'd1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign count      = cnt_q;
  assign head_valid = (cnt_q != 3'd0);
  assign head_data  = buf_q[rd_q];

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller owning one single-port RAM: alternates the port between writes and reads
// under contention and buffers read data in a small obuf. Optional macro: FIFO_BYPASS_EN.
module sp_ram_fifo_ctrl
  import sp_ram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = 8,
  parameter int unsigned WIDTH_ADDR = 8,
  parameter string       DOUT_REG   = "false"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WIDTH_DATA-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH_DATA-1:0] out_data,
  input  logic                  out_ready,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [WIDTH_ADDR-1:0] mem_addr,
  output logic [WIDTH_DATA-1:0] mem_din,
  input  logic [WIDTH_DATA-1:0] mem_dout,
  output logic [WIDTH_ADDR+1:0] count
);

  localparam int unsigned LAT  = rd_lat(DOUT_REG);
  localparam int unsigned CNTW = WIDTH_ADDR + 2;
  localparam logic [WIDTH_ADDR:0] DEPTH = {1'b1, {WIDTH_ADDR{1'b0}}};

  logic [WIDTH_ADDR-1:0] wr_ptr_q, rd_ptr_q;
  logic [WIDTH_ADDR:0]   mem_cnt_q;
  logic                  prio_rd_q;
  logic [LAT-1:0]        inflight_q;
  logic [1:0]            inflight_cnt;
  logic [2:0]            obuf_cnt;
  logic                  obuf_push, obuf_pop;
  logic [WIDTH_DATA-1:0] obuf_push_data;
  logic                  rd_elig, push_acc, bypass;
  gnt_e                  gnt;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < LAT; i++) inflight_cnt = inflight_cnt + 2'(inflight_q[i]);
  end

  // Reads only issue when the obuf is guaranteed room for everything already in flight.
  assign rd_elig = (mem_cnt_q != '0) &&
                   ((4'(obuf_cnt) + 4'(inflight_cnt)) < 4'(OBUF_DEPTH));

  assign obuf_pop = out_valid && out_ready;

  always_comb begin
    in_ready = rst_n && (mem_cnt_q != DEPTH) && !(rd_elig && prio_rd_q);
    bypass   = 1'b0;
`ifdef FIFO_BYPASS_EN
    // Nothing older in RAM or in flight, so the push may go straight into the obuf.
    if (rst_n && (mem_cnt_q == '0) && (inflight_cnt == '0) &&
        ((obuf_cnt < 3'(OBUF_DEPTH)) || obuf_pop)) begin
      in_ready = 1'b1;
      bypass   = in_valid;
    end
`endif
    push_acc = in_valid && in_ready;
    if (push_acc && !bypass) gnt = GNT_WR;
    else if (rd_elig)        gnt = GNT_RD;
    else                     gnt = GNT_IDLE;

    mem_wen  = (gnt == GNT_WR);
    mem_ren  = (gnt == GNT_RD);
    mem_addr = '0;
    mem_din  = '0;
    unique case (gnt)
      GNT_WR: begin
        mem_addr = wr_ptr_q;
        mem_din  = in_data;
      end
      GNT_RD:  mem_addr = rd_ptr_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      prio_rd_q  <= 1'b0;
      inflight_q <= '0;
    end else begin
      inflight_q <= LAT'({inflight_q, (gnt == GNT_RD)});
      unique case (gnt)
        GNT_WR: begin
          wr_ptr_q  <= wr_ptr_q + 1'b1;
          mem_cnt_q <= mem_cnt_q + 1'b1;
          prio_rd_q <= 1'b1;
        end
        GNT_RD: begin
          rd_ptr_q  <= rd_ptr_q + 1'b1;
          mem_cnt_q <= mem_cnt_q - 1'b1;
          prio_rd_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The oldest in-flight stage marks the cycle mem_dout carries that read's data.
  assign obuf_push      = inflight_q[LAT-1] || bypass;
  assign obuf_push_data = bypass ? in_data : mem_dout;

  sp_ram_fifo_obuf #(
    .WIDTH_DATA(WIDTH_DATA)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (obuf_push),
    .push_data (obuf_push_data),
    .pop       (obuf_pop),
    .count     (obuf_cnt),
    .head_valid(out_valid),
    .head_data (out_data)
  );

  assign count = CNTW'(mem_cnt_q) + CNTW'(inflight_cnt) + CNTW'(obuf_cnt);

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Scoreboard bench for sp_ram_fifo_ctrl with a behavioural RAM; honours FIFO_BYPASS_EN if set.
module tb_sp_ram_fifo_ctrl;

  localparam int unsigned WD          = 8;
  localparam int unsigned WA          = 8;
  localparam string       TB_DOUT_REG = "false";
  localparam int          LAT         = int'(sp_ram_fifo_pkg::rd_lat(TB_DOUT_REG));
  localparam int          DEPTH       = 1 << WA;
`ifdef FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int EXP_LAT = BYP ? 1 : 2 + LAT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [WD-1:0] in_data, out_data;
  logic          mem_wen, mem_ren;
  logic [WA-1:0] mem_addr;
  logic [WD-1:0] mem_din, mem_dout;
  logic [WA+1:0] count;

  always #5 clk = ~clk;

  sp_ram_fifo_ctrl #(
    .WIDTH_DATA(WD),
    .WIDTH_ADDR(WA),
    .DOUT_REG  (TB_DOUT_REG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .mem_wen  (mem_wen),
    .mem_ren  (mem_ren),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .count    (count)
  );

  // Behavioural single-port RAM with read latency LAT.
  logic [WD-1:0] ram [DEPTH];
  logic [WD-1:0] ram_q1, ram_q2;
  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr] <= mem_din;
    if (mem_ren) ram_q1 <= ram[mem_addr];
    ram_q2 <= ram_q1;
  end
  assign mem_dout = (LAT == 2) ? ram_q2 : ram_q1;

  int n_chk = 0;
  int n_err = 0;
  logic [WD-1:0] exp_q[$];
  int model_cnt = 0;
  int push_tot = 0, pop_tot = 0, wen_tot = 0, ren_tot = 0;
  int seq = 0;
  bit data_mode = 1'b0;
  logic [WD-1:0] last_pop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: mirrors accepted pushes into the queue and checks every pop and invariant.
  bit prev_stall = 1'b0, prev_nrdy = 1'b0;
  logic [WD-1:0] prev_data;
  int prev_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_nrdy  = 1'b0;
    end else begin
      check("count", 32'(count), 32'(model_cnt));
      check("one_op_per_cycle", 32'(mem_wen & mem_ren), 32'd0);
      if (model_cnt == 0) check("ready_when_empty", 32'(in_ready), 32'd1);
      if (prev_nrdy && prev_cnt < DEPTH) check("ready_recovers", 32'(in_ready), 32'd1);
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      prev_cnt = model_cnt;
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        push_tot++;
        model_cnt++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
        else check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
        last_pop = out_data;
        pop_tot++;
        model_cnt--;
      end
      wen_tot += int'(mem_wen);
      ren_tot += int'(mem_ren);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_nrdy  = !in_ready;
    end
  end

  // vmode/rmode: 0 = low, 1 = high, 2 = random, 3 (rmode) = toggle.
  task automatic run_cycles(input int n, input int vmode, input int rmode, input int limit);
    bit acc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) seq++;
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        case (vmode)
          0:       in_valid = 1'b0;
          1:       in_valid = 1'b1;
          default: in_valid = ($urandom_range(0, 1) == 1);
        endcase
        in_data = data_mode ? WD'($urandom) : WD'(seq);
      end
      if (vmode == 0 || (limit >= 0 && seq >= limit)) in_valid = 1'b0;
      case (rmode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = !out_ready;
      endcase
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
    check({tag, "_mem_ren"}, 32'(mem_ren), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_din"}, 32'(mem_din), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, w0, r0, q0, pops_before;
    bit popped;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single push of 0x11 into an empty FIFO.
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk);
    check("single_wen", 32'(mem_wen), BYP ? 32'd0 : 32'd1);
    if (!BYP) begin
      check("single_waddr", 32'(mem_addr), 32'd0);
      check("single_din", 32'(mem_din), 32'h11);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k < EXP_LAT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("single_ren", 32'(mem_ren), 32'd1);
        check("single_raddr", 32'(mem_addr), 32'd0);
        check("single_count", 32'(count), 32'd1);
      end
      check("single_not_yet_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'h11);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;

    // Fill to capacity with a counting pattern, then drain in order.
    seq = 0; data_mode = 1'b0;
    run_cycles(700, 1, 0, DEPTH + 5);
    @(negedge clk);
    check("full_count", 32'(count), 32'(DEPTH + 4));
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_pushes", 32'(seq), 32'(DEPTH + 4));
    check("full_head_valid", 32'(out_valid), 32'd1);
    check("full_head_data", 32'(out_data), 32'h00);
    run_cycles(700, 0, 1, -1);
    @(negedge clk);
    check("drained_count", 32'(count), 32'd0);

    // Continuous push and pop: half rate each way, crossing the pointer wrap.
    data_mode = 1'b1;
    run_cycles(50, 1, 1, -1);
    p0 = push_tot; w0 = wen_tot; r0 = ren_tot; q0 = pop_tot;
    run_cycles(400, 1, 1, -1);
    check("stream_push_rate", 32'(push_tot - p0 >= 195), 32'd1);
    check("stream_pop_rate", 32'(pop_tot - q0 >= 195), 32'd1);
    if (!BYP) begin
      check("stream_wen_rate", 32'(wen_tot - w0 >= 195), 32'd1);
      check("stream_ren_rate", 32'(ren_tot - r0 >= 195), 32'd1);
    end
    run_cycles(30, 0, 1, -1);

    // Toggling out_ready, then fully random traffic.
    run_cycles(300, 2, 3, -1);
    run_cycles(1500, 2, 2, -1);
    run_cycles(300, 0, 1, -1);
    @(negedge clk);
    check("random_drained", 32'(count), 32'd0);

    // Asynchronous reset in the middle of a burst with reads in flight.
    run_cycles(6, 1, 0, -1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    model_cnt = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_idle", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    pops_before = pop_tot;
    popped = 1'b0;
    for (int k = 0; k < 20 && !popped; k++) begin
      @(negedge clk);
      popped = (pop_tot != pops_before);
    end
    check("post_reset_popped", 32'(popped), 32'd1);
    check("post_reset_first", 32'(last_pop), 32'hA5);
    @(posedge clk); #1 out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
